// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared segment patterns, converter states and core state codes for the score display
package ssd_pkg;

    localparam int MAX_DISP = 9999;
    localparam logic [3:0] FAIL_STATE = 4'd3;

    // Active-low segments, bit6 = Ca ... bit0 = Cg.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - serial double-dabble converter, one bit per cycle, result register updated only on completion
module bin2bcd_serial
    import ssd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      bcd_o
);

    localparam int SH_W  = 16 + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SH_W-1:0]  sh_q;
    logic [SH_W-1:0]  sh_d;

    // BCD digits sit above the binary bits; correct every nibble before the shift.
    always_comb begin
        sh_d = sh_q;
        for (int i = 0; i < 4; i++) begin
            if (sh_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                sh_d[BIN_W + 4*i +: 4] = sh_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        sh_d = sh_d << 1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            bcd_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sh_q    <= {16'b0, bin_i};
                        cnt_q   <= '0;
                        busy_o  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_o   <= sh_q[BIN_W +: 16];
                    busy_o  <= 1'b0;
                    done_o  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/score_ssd_driver.sv
// rtl/score_ssd_driver.sv - score to 4-digit multiplexed seven-segment driver; optional SSD_GAMEOVER_BLINK_EN blinks on game over
module score_ssd_driver
    import ssd_pkg::*;
#(
    parameter int SCORE_W = 14,
    parameter int SCAN_W  = 18
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [SCORE_W-1:0] score,
    input  logic [3:0]         state,
    output logic [6:0]         ssdOut,
    output logic [3:0]         anode,
    output logic               busy
);

    logic [SCORE_W-1:0] last_score_q;
    logic [SCORE_W-1:0] clamp_score;
    logic               conv_busy;
    logic               conv_done_unused;
    logic               start;
    logic [15:0]        disp_bcd;

    assign clamp_score = (score > SCORE_W'(MAX_DISP)) ? SCORE_W'(MAX_DISP) : score;
    // The converter is idle exactly when busy is low, so a pending change restarts it right after DONE.
    assign start = (score != last_score_q) && !conv_busy;
    assign busy  = conv_busy;

    bin2bcd_serial #(
        .BIN_W(SCORE_W)
    ) u_bin2bcd (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .start_i(start),
        .bin_i  (clamp_score),
        .busy_o (conv_busy),
        .done_o (conv_done_unused),
        .bcd_o  (disp_bcd)
    );

    logic [SCAN_W-1:0] scan_q;
    logic [1:0]        sel;
    logic [3:0]        digit;
    logic              blank;
    logic [6:0]        seg_d;
    logic [3:0]        anode_d;
    logic [6:0]        seg_q;
    logic [3:0]        anode_q;
    logic              blank_all;

    assign sel = scan_q[SCAN_W-1 -: 2];

    always_comb begin
        blank   = 1'b0;
        digit   = disp_bcd[{sel, 2'b00} +: 4];
        case (sel)
            2'd1:    blank = (disp_bcd[15:4] == 12'd0);
            2'd2:    blank = (disp_bcd[15:8] == 8'd0);
            2'd3:    blank = (disp_bcd[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        seg_d   = blank ? SEG_BLANK : seg_decode(digit);
        anode_d = ~(4'b0001 << sel);
    end

`ifdef SSD_GAMEOVER_BLINK_EN
    logic [24:0] blink_q;

    always_ff @(posedge CLK) begin
        if (RESET || (state != FAIL_STATE)) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + 25'd1;
        end
    end

    assign blank_all = blink_q[24];
`else
    logic state_unused;
    assign state_unused = ^state;
    assign blank_all    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            scan_q       <= '0;
            anode_q      <= 4'hF;
            seg_q        <= SEG_BLANK;
            last_score_q <= '0;
        end else begin
            scan_q  <= scan_q + SCAN_W'(1);
            anode_q <= blank_all ? 4'hF : anode_d;
            seg_q   <= seg_d;
            if (start) begin
                last_score_q <= score;
            end
        end
    end

    assign ssdOut = seg_q;
    assign anode  = anode_q;

endmodule

// File: tb/tb_score_ssd_driver.sv
// tb/tb_score_ssd_driver.sv - directed and random checks of the score display against a decimal reference model
module tb_score_ssd_driver;

    localparam int SCORE_W = 14;
    localparam int SCAN_W  = 4;
    localparam int FRAME   = 1 << SCAN_W;

    logic               CLK = 1'b0;
    logic               RESET;
    logic [SCORE_W-1:0] score;
    logic [3:0]         state;
    logic [6:0]         ssdOut;
    logic [3:0]         anode;
    logic               busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_edges = 0;
    logic [6:0] seg_tab [10];

    score_ssd_driver #(
        .SCORE_W(SCORE_W),
        .SCAN_W (SCAN_W)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .score (score),
        .state (state),
        .ssdOut(ssdOut),
        .anode (anode),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RESET) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    // Decimal digit k of v, blank when v has fewer than k+1 significant digits.
    function automatic logic [6:0] exp_seg(input int v, input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (k > 0 && v < p) return 7'h7F;
        return seg_tab[(v / p) % 10];
    endfunction

    // Digit lit after n edges out of reset: counter value n-1, top two bits.
    function automatic int exp_sel();
        return ((n_edges - 1) >> (SCAN_W - 2)) & 3;
    endfunction

    task automatic set_score(input int v);
        @(negedge CLK);
        score = SCORE_W'(v);
    endtask

    task automatic settle(input string tag);
        repeat (40) @(negedge CLK);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic frame_check(input int v, input string tag);
        int bad_an = 0;
        int bad_seg = 0;
        int bad_busy = 0;
        int k;
        repeat (2 * FRAME) begin
            @(negedge CLK);
            k = exp_sel();
            if (anode !== ~(4'b0001 << k)) bad_an++;
            if (ssdOut !== exp_seg(v, k)) bad_seg++;
            if (busy !== 1'b0) bad_busy++;
        end
        chk({tag, "_anode_bad_cycles"}, bad_an, 0);
        chk({tag, "_seg_bad_cycles"}, bad_seg, 0);
        chk({tag, "_busy_cycles"}, bad_busy, 0);
    endtask

    task automatic conv_timing(input int old_v, input int new_v, input string tag);
        int hi = 0;
        int first = -1;
        set_score(new_v);
        for (int s = 1; s <= 17; s++) begin
            @(negedge CLK);
            if (busy === 1'b1) begin
                hi++;
                if (first < 0) first = s;
            end
            if (s == 16) chk({tag, "_seg_before_update"}, ssdOut, exp_seg(old_v, exp_sel()));
            if (s == 17) chk({tag, "_seg_after_update"}, ssdOut, exp_seg(new_v, exp_sel()));
        end
        chk({tag, "_busy_len"}, hi, 15);
        chk({tag, "_busy_rise"}, first, 1);
    endtask

    initial begin
        int k, v, bad, last5, first42, seen5;
        logic [6:0] p_old, p5, p42;

        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
        seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;

        RESET = 1'b1;
        score = '0;
        state = 4'd0;
        repeat (2) @(negedge CLK);
        chk("reset_anode", anode, 4'hF);
        chk("reset_seg", ssdOut, 7'h7F);
        chk("reset_busy", busy, 0);
        RESET = 1'b0;
        frame_check(0, "zero");

        conv_timing(0, 1234, "c1234");
        frame_check(1234, "d1234");

        set_score(12000);
        settle("s12000");
        frame_check(9999, "clamp");

        // Change 5 -> 42 while the 5 conversion is in its third cycle.
        set_score(5);
        repeat (3) @(negedge CLK);
        score = 14'd42;
        bad = 0; last5 = -1; first42 = -1; seen5 = 0;
        for (int s = 0; s < 48; s++) begin
            @(negedge CLK);
            k = exp_sel();
            p_old = exp_seg(9999, k);
            p5    = exp_seg(5, k);
            p42   = exp_seg(42, k);
            if (ssdOut !== p_old && ssdOut !== p5 && ssdOut !== p42) bad++;
            if (ssdOut === p5 && p5 !== p42 && p5 !== p_old) begin
                seen5 = 1;
                last5 = s;
            end
            if (ssdOut === p42 && p42 !== p5 && p42 !== p_old && first42 < 0) first42 = s;
        end
        chk("race_no_other_value", bad, 0);
        chk("race_five_shown", seen5, 1);
        chk("race_five_before_42", (last5 >= 0 && first42 > last5) ? 1 : 0, 1);
        frame_check(42, "d42");

        set_score(7);
        settle("s7");
        frame_check(7, "d7");

        set_score(3210);
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midreset_anode", anode, 4'hF);
        chk("midreset_seg", ssdOut, 7'h7F);
        chk("midreset_busy", busy, 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("midreset_restart_busy", busy, 1);
        settle("s3210");
        frame_check(3210, "d3210");

        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 16383));
            set_score(v);
            settle("rand");
            frame_check(clampv(v), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
